pipe_skid_reg: RTL and testbench

Parametrised inter-stage pipeline register (EX→MEM, MEM→WB, and similar) with a valid/ready handshake.
- Full-throughput two-entry skid buffer: in_ready is driven directly from a flop, so the ready path is cut between stages.
- Synchronous flush input for branch and exception kill.
- Side-effect flags (write-enable, mem-read, and similar) are forced to zero whenever the output is not valid, so bypass and forwarding logic can use them directly.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_skid_entry.sv | 54 +++++
 rtl/pipe_skid_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_skid_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: default widths,
// the canonical stage payload layout and side-effect flag bit positions.
package pipe_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_FLAG_W = 2;
    localparam int PIPE_PERF_W = 32;

    localparam int FLAG_RF_WE  = 0;
    localparam int FLAG_MEM_RE = 1;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] inst;
    } stage_payload_t;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_FROM_IN,
        MAIN_FROM_SKID,
        MAIN_CLEAR
    } main_op_e;

    typedef enum logic [1:0] {
        SKID_HOLD,
        SKID_FROM_IN,
        SKID_CLEAR
    } skid_op_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline-register slot: valid bit plus payload and flags.
// A load always wins over a clear; payload changes only on a load.
module pipe_skid_entry #(
    parameter int DATA_W = 64,
    parameter int FLAG_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_d,
    input  logic [FLAG_W-1:0] load_f,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [FLAG_W-1:0] flags
);

    logic              v_d, v_q;
    logic [DATA_W-1:0] d_d, d_q;
    logic [FLAG_W-1:0] f_d, f_q;

    always_comb begin
        // NOTE: every signal written here gets a hold default first, so no path infers a latch.
        v_d = v_q;
        d_d = d_q;
        f_d = f_q;
        if (load) begin
            v_d = 1'b1;
            d_d = load_d;
            f_d = load_f;
        end else if (clear) begin
            v_d = 1'b0;
        end
    end

    // NOTE: payload registers are reset as well, so out_data reads a defined 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
            f_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            v_q <= v_d;
            d_q <= d_d;
            f_q <= f_d;
        end
    end

    assign valid = v_q;
    assign data  = d_q;
    assign flags = f_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered in_ready, synchronous flush
// and valid-masked side-effect flags. Define PIPE_SKID_PERF_EN for perf counters.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int FLAG_W = PIPE_FLAG_W
`ifdef PIPE_SKID_PERF_EN
    ,
    parameter int PERF_W = PIPE_PERF_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_d, skid_d;
    logic [FLAG_W-1:0] main_f, skid_f;

    logic              acc, deq;
    main_op_e          main_op;
    skid_op_e          skid_op;

    logic              main_load, main_clear;
    logic [DATA_W-1:0] main_load_d;
    logic [FLAG_W-1:0] main_load_f;
    logic              skid_load, skid_clear;
    logic              skid_v_next;
    logic              in_ready_d, in_ready_q;

    assign acc = in_valid & in_ready_q;
    assign deq = main_v & out_ready;

    // Skid is only ever occupied while main is, so main empty implies skid empty.
    always_comb begin
        main_op = MAIN_HOLD;
        skid_op = SKID_HOLD;
        if (flush) begin
            main_op = MAIN_CLEAR;
            skid_op = SKID_CLEAR;
        end else if (!main_v) begin
            if (acc) main_op = MAIN_FROM_IN;
        end else if (deq) begin
            if (skid_v) begin
                main_op = MAIN_FROM_SKID;
                skid_op = acc ? SKID_FROM_IN : SKID_CLEAR;
            end else begin
                main_op = acc ? MAIN_FROM_IN : MAIN_CLEAR;
            end
        end else if (acc) begin
            skid_op = SKID_FROM_IN;
        end
    end

    always_comb begin
        main_load   = (main_op == MAIN_FROM_IN) || (main_op == MAIN_FROM_SKID);
        main_clear  = (main_op == MAIN_CLEAR);
        main_load_d = (main_op == MAIN_FROM_SKID) ? skid_d : in_data;
        main_load_f = (main_op == MAIN_FROM_SKID) ? skid_f : in_flags;
        skid_load   = (skid_op == SKID_FROM_IN);
        skid_clear  = (skid_op == SKID_CLEAR);

        skid_v_next = skid_v;
        if (skid_load)       skid_v_next = 1'b1;
        else if (skid_clear) skid_v_next = 1'b0;
        in_ready_d = ~skid_v_next;
    end

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .FLAG_W (FLAG_W)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clear),
        .load_d (main_load_d),
        .load_f (main_load_f),
        .valid  (main_v),
        .data   (main_d),
        .flags  (main_f)
    );

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .FLAG_W (FLAG_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .clear  (skid_clear),
        .load_d (in_data),
        .load_f (in_flags),
        .valid  (skid_v),
        .data   (skid_d),
        .flags  (skid_f)
    );

    // Dedicated flop keeps in_ready free of any combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign out_flags = main_f & {FLAG_W{main_v}};

`ifdef PIPE_SKID_PERF_EN
    logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_v && !out_ready)          stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if (flush && (main_v || skid_v))   flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    a_skid_implies_main : assert property (@(posedge clk) disable iff (!rst_n)
        !(skid_v && !main_v));
    a_no_acc_when_skid_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(skid_v && acc));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, hand-written
// reset/perf sequences and random traffic against a queue-based model.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int DATA_W = 64;
    localparam int FLAG_W = 2;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [FLAG_W-1:0] in_flags = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [FLAG_W-1:0] out_flags;
`ifdef PIPE_SKID_PERF_EN
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
`ifdef PIPE_SKID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Reference model: a FIFO of at most two beats plus the last head payload.
    typedef struct {
        logic [DATA_W-1:0] d;
        logic [FLAG_W-1:0] f;
    } beat_t;

    beat_t             mq[$];
    logic [DATA_W-1:0] m_last_head = '0;
    longint            m_stall = 0;
    longint            m_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last_head = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_edge();
        bit    acc;
        bit    deq;
        beat_t b;
        acc = in_valid && (mq.size() < 2);
        deq = (mq.size() > 0) && out_ready;
        if (mq.size() > 0 && !out_ready) m_stall++;
        if (flush) begin
            if (mq.size() > 0) m_flush++;
            mq.delete();
        end else begin
            if (deq) mq.delete(0);
            if (acc) begin
                b.d = in_data;
                b.f = in_flags;
                mq.push_back(b);
            end
        end
        if (mq.size() > 0) m_last_head = mq[0].d;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ov"}, 64'(out_valid), 64'(mq.size() > 0));
        check({tag, "_ir"}, 64'(in_ready), 64'(mq.size() < 2));
        check({tag, "_of"}, 64'(out_flags), (mq.size() > 0) ? 64'(mq[0].f) : 64'd0);
        check({tag, "_od"}, out_data, m_last_head);
`ifdef PIPE_SKID_PERF_EN
        check({tag, "_stall"}, 64'(perf_stall_cnt), 64'(m_stall[PERF_W-1:0]));
        check({tag, "_flush"}, 64'(perf_flush_cnt), 64'(m_flush[PERF_W-1:0]));
`endif
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [DATA_W-1:0] d,
                         input logic [FLAG_W-1:0] f, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_flags  = f;
        out_ready = ordy;
    endtask

    typedef struct {
        logic              fl;
        logic              iv;
        logic [DATA_W-1:0] d;
        logic [FLAG_W-1:0] f;
        logic              ordy;
        logic              e_ov;
        logic              e_ir;
        logic [DATA_W-1:0] e_od;
        logic [FLAG_W-1:0] e_of;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        // Backpressure A,B,C with C held upstream, then release.
        vecs[0]  = '{1'b0, 1'b1, 64'hA,  2'b11, 1'b0, 1'b1, 1'b1, 64'hA,  2'b11};
        vecs[1]  = '{1'b0, 1'b1, 64'hB,  2'b11, 1'b0, 1'b1, 1'b0, 64'hA,  2'b11};
        vecs[2]  = '{1'b0, 1'b1, 64'hC,  2'b01, 1'b0, 1'b1, 1'b0, 64'hA,  2'b11};
        vecs[3]  = '{1'b0, 1'b1, 64'hC,  2'b01, 1'b1, 1'b1, 1'b1, 64'hB,  2'b11};
        vecs[4]  = '{1'b0, 1'b1, 64'hC,  2'b01, 1'b1, 1'b1, 1'b1, 64'hC,  2'b01};
        vecs[5]  = '{1'b0, 1'b0, 64'h0,  2'b00, 1'b1, 1'b0, 1'b1, 64'hC,  2'b00};
        // Flush with both entries full and a concurrent offer of D.
        vecs[6]  = '{1'b0, 1'b1, 64'h1A, 2'b11, 1'b0, 1'b1, 1'b1, 64'h1A, 2'b11};
        vecs[7]  = '{1'b0, 1'b1, 64'h1B, 2'b11, 1'b0, 1'b1, 1'b0, 64'h1A, 2'b11};
        vecs[8]  = '{1'b1, 1'b1, 64'hD,  2'b10, 1'b0, 1'b0, 1'b1, 64'h1A, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 64'hD,  2'b10, 1'b1, 1'b0, 1'b1, 64'h1A, 2'b00};
        // Flag masking: flags visible only while valid, payload held.
        vecs[10] = '{1'b0, 1'b1, 64'h55, 2'(1 << FLAG_RF_WE), 1'b0, 1'b1, 1'b1, 64'h55, 2'b01};
        vecs[11] = '{1'b0, 1'b0, 64'h0,  2'b11, 1'b1, 1'b0, 1'b1, 64'h55, 2'b00};
        vecs[12] = '{1'b0, 1'b0, 64'h0,  2'b11, 1'b0, 1'b0, 1'b1, 64'h55, 2'b00};
        // Flush with concurrent deq, then flush while empty with an offer.
        vecs[13] = '{1'b0, 1'b1, 64'h66, 2'(1 << FLAG_MEM_RE), 1'b1, 1'b1, 1'b1, 64'h66, 2'b10};
        vecs[14] = '{1'b1, 1'b0, 64'h0,  2'b00, 1'b1, 1'b0, 1'b1, 64'h66, 2'b00};
        vecs[15] = '{1'b1, 1'b1, 64'h77, 2'b11, 1'b0, 1'b0, 1'b1, 64'h66, 2'b00};
        vecs[16] = '{1'b0, 1'b0, 64'h0,  2'b00, 1'b1, 1'b0, 1'b1, 64'h66, 2'b00};

        // Power-on reset.
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check("por_ov", 64'(out_valid), 64'd0);
        check("por_ir", 64'(in_ready), 64'd1);
        check("por_od", out_data, 64'd0);
        check("por_of", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 1..8 at full throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, DATA_W'(i), FLAG_W'(i), 1'b1);
            cycle();
            check($sformatf("stream%0d_od", i), out_data, 64'(i));
            check($sformatf("stream%0d_ov", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d_ir", i), 64'(in_ready), 64'd1);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cycle();
        check_model("stream_end");

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].f, vecs[i].ordy);
            cycle();
            check($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(vecs[i].e_ir));
            check($sformatf("vec%0d_od", i), out_data, vecs[i].e_od);
            check($sformatf("vec%0d_of", i), 64'(out_flags), 64'(vecs[i].e_of));
        end

        // Asynchronous reset with both entries full.
        drive(1'b0, 1'b1, 64'h91, 2'b11, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 64'h92, 2'b11, 1'b0);
        cycle();
        check("midrst_full_ir", 64'(in_ready), 64'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_ov", 64'(out_valid), 64'd0);
        check("midrst_ir", 64'(in_ready), 64'd1);
        check("midrst_od", out_data, 64'd0);
        check("midrst_of", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cycle();
        check_model("postrst");

`ifdef PIPE_SKID_PERF_EN
        check("perf_rst_stall", 64'(perf_stall_cnt), 64'd0);
        check("perf_rst_flush", 64'(perf_flush_cnt), 64'd0);
        drive(1'b0, 1'b1, 64'h1, 2'b01, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 64'h2, 2'b01, 1'b0);
        cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        check("perf_stall5", 64'(perf_stall_cnt), 64'd5);
        check("perf_flush0", 64'(perf_flush_cnt), 64'd0);
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        cycle();
        check("perf_stall_after_flush", 64'(perf_stall_cnt), 64'd5);
        check("perf_flush1", 64'(perf_flush_cnt), 64'd1);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        cycle();
        check("perf_flush_empty", 64'(perf_flush_cnt), 64'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cycle();
`endif

        // Random traffic against the model; payload is random even when not valid.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(15) == 0), ($urandom_range(1) == 1),
                  {$urandom, $urandom}, FLAG_W'($urandom),
                  ($urandom_range(3) != 0));
            cycle();
            check_model($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
